// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial word adder.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_W = 8;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with a loadable, enabled carry register.
module serial_fa_cell (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_val,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_in_q,
  output logic carry_d
);

  assign sum     = a ^ b ^ carry_in_q;
  assign carry_d = (a & b) | (a & carry_in_q) | (b & carry_in_q);

  // load takes priority so a fresh operand pair always starts from the seeded carry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_in_q <= 1'b0;
    end else if (load) begin
      carry_in_q <= load_val;
    end else if (en) begin
      carry_in_q <= carry_d;
    end
  end

endmodule

// File: rtl/serial_word_adder.sv
// Word-level front end: accepts operands, streams them LSB-first through
// a one-bit adder cell and returns the parallel result with carry/overflow.
import serial_arith_pkg::*;

module serial_word_adder #(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_carry,
  output logic         out_overflow
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  res_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          out_valid_q;
  logic          in_ready_q;

  logic          accept;
  logic          fa_en;
  logic          fa_sum;
  logic          carry_q;
  logic          carry_d;

  assign accept = in_valid & in_ready_q;
  assign fa_en  = (state_q == SHIFT);

  serial_fa_cell u_fa (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_val   (in_sub),
    .en         (fa_en),
    .a          (a_q[0]),
    .b          (b_q[0]),
    .sum        (fa_sum),
    .carry_in_q (carry_q),
    .carry_d    (carry_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q        <= in_a;
            // subtraction is A + ~B + 1; the +1 comes from the seeded carry
            b_q        <= in_sub ? ~in_b : in_b;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {fa_sum, res_q[W-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            // carry into MSB xor carry out of MSB
            ovf_q       <= carry_q ^ carry_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = res_q;
  assign out_carry    = carry_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_serial_word_adder.sv
// Self-checking bench for serial_word_adder (W=8) against an arithmetic model.
module tb_serial_word_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sum;
  logic       out_carry;
  logic       out_overflow;

  int npass = 0;
  int ntotal = 0;
  int cyc = 0;

  serial_word_adder #(.W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sub       (in_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carry    (out_carry),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Plain arithmetic reference: modulo-256 result, unsigned carry/no-borrow, signed overflow.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                output logic [7:0] s, output logic c, output logic v);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    if (!sub) begin
      r = ai + bi;
      s = r[7:0];
      c = (r > 255);
      v = (a[7] == b[7]) && (s[7] != a[7]);
    end else begin
      r = ai - bi;
      s = r[7:0];
      c = (ai >= bi);
      v = (a[7] != b[7]) && (s[7] != a[7]);
    end
  endfunction

  // Called at a negedge; returns at a negedge with the result consumed or about to be.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input int hold, output int acc_cyc);
    logic [7:0] es;
    logic ec, ev;
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_sub = ~sub;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      chk("out_valid_early", out_valid, 0);
    end
    @(posedge clk); #1;
    model(a, b, sub, es, ec, ev);
    chk("out_valid_at_w", out_valid, 1);
    chk("out_sum", out_sum, es);
    chk("out_carry", out_carry, ec);
    chk("out_overflow", out_overflow, ev);
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum, es);
      chk("hold_flags", {out_carry, out_overflow}, {ec, ev});
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t0, t1;
    logic [7:0] ra, rb;
    logic rs;

    // reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_flags", {out_carry, out_overflow}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // directed cases
    run_op(8'h5A, 8'h33, 1'b0, 0, t0);
    run_op(8'hFF, 8'h01, 1'b0, 0, t0);
    run_op(8'h10, 8'h20, 1'b1, 0, t0);
    run_op(8'h80, 8'h01, 1'b1, 0, t0);

    // backpressure, then back-to-back interval
    run_op(8'h7F, 8'h7F, 1'b0, 5, t0);
    run_op(8'h12, 8'h34, 1'b0, 0, t0);
    run_op(8'hC3, 8'h3C, 1'b1, 0, t1);
    chk("back_to_back_interval", t1 - t0, 10);

    // reset mid-operation at count=3 of 0x00-0x01
    in_a = 8'h00; in_b = 8'h01; in_sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_sum", out_sum, 0);
    chk("midrst_flags", {out_carry, out_overflow}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    run_op(8'h01, 8'h01, 1'b0, 0, t0);

    // randomized operations with occasional backpressure
    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      if (n % 6 == 0) rb = ra;
      run_op(ra, rb, rs, int'($urandom_range(0, 2)), t0);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
